// File: rtl/led_or_scheduler_pkg.sv
// Shared types and defaults for the LED OR scheduler: FSM state encoding
// and default sizing constants.
package led_or_scheduler_pkg;
  localparam int NUM_PAIRS_DEF = 7;
  localparam int DWELL_DEF     = 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, EVAL, DONE} state_e;
endpackage

// File: rtl/led_or_scheduler_pair_or2.sv
// Single shared 2-input OR evaluator; the scheduler time-multiplexes it
// across all input pairs.
module pair_or2 (
  input  logic [1:0] a,
  output logic       y
);
  assign y = a[0] | a[1];
endmodule

// File: rtl/led_or_scheduler.sv
// Scans input pairs one at a time through a shared OR unit, building a shadow
// result that is published to o_led in a single edge when the scan finishes.
module led_or_scheduler
  import led_or_scheduler_pkg::*;
#(
  parameter int NUM_PAIRS = NUM_PAIRS_DEF,
  parameter int DWELL     = DWELL_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cont_mode,
  input  logic [2*NUM_PAIRS-1:0] in,
  output logic [NUM_PAIRS-1:0]   o_led,
  output logic                   busy,
  output logic                   done
);
  localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int DC_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PAIRS - 1);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DWELL - 1);

  state_e                     state;
  logic [2*NUM_PAIRS-1:0]     in_q;
  logic [NUM_PAIRS-1:0]       shadow;
  logic [NUM_PAIRS-1:0]       shadow_nxt;
  logic [NUM_PAIRS-1:0][1:0]  pairs;
  logic [IDX_W-1:0]           idx;
  logic [DC_W-1:0]            dwell_cnt;
  logic                       or_y;

  assign pairs = in_q;

  pair_or2 u_or (
    .a (pairs[idx]),
    .y (or_y)
  );

  // Shadow with the current pair folded in, so the final write and the
  // o_led publish can happen on the same edge.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[idx] = or_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      o_led     <= '0;
      shadow    <= '0;
      in_q      <= '0;
      idx       <= '0;
      dwell_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start || cont_mode) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          in_q      <= in;
          idx       <= '0;
          dwell_cnt <= '0;
          state     <= EVAL;
        end
        EVAL: begin
          if (dwell_cnt == DC_LAST) begin
            shadow    <= shadow_nxt;
            dwell_cnt <= '0;
            if (idx == IDX_LAST) begin
              o_led <= shadow_nxt;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (cont_mode) begin
            state <= CAPTURE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_or_scheduler.sv
// Directed scoreboard bench: stimulus pushes expected (done cycle, o_led)
// pairs, per-DUT monitors pop and compare on every done pulse.
module tb_led_or_scheduler;
  localparam int NP  = 7;
  localparam int DW1 = 1;
  localparam int DW3 = 3;

  typedef struct {
    int         e;
    logic [6:0] led;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s1, c1, s3, c3;
  logic [13:0] i1, i3;
  logic [6:0]  l1, l3;
  logic        b1, d1, b3, d3;
  int          total = 0;
  int          bad   = 0;
  int          edge_cnt = 0;
  exp_t        q1[$];
  exp_t        q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  led_or_scheduler #(.NUM_PAIRS(NP), .DWELL(DW1)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .cont_mode(c1), .in(i1),
    .o_led(l1), .busy(b1), .done(d1)
  );

  led_or_scheduler #(.NUM_PAIRS(NP), .DWELL(DW3)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .cont_mode(c3), .in(i3),
    .o_led(l3), .busy(b3), .done(d3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Monitors: every done pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && d1) begin
      if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_done_cycle", edge_cnt, e.e);
        chk("d1_o_led", {25'd0, l1}, {25'd0, e.led});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && d3) begin
      if (q3.size() == 0) chk("d3_unexpected_done", 1, 0);
      else begin
        e = q3.pop_front();
        chk("d3_done_cycle", edge_cnt, e.e);
        chk("d3_o_led", {25'd0, l3}, {25'd0, e.led});
      end
    end
  end

  // Pulse start on dut1; returns at the negedge of cycle 1.
  task automatic go1(input logic [13:0] v, input bit expect_done, input logic [6:0] led);
    @(negedge clk);
    i1 = v;
    s1 = 1'b1;
    if (expect_done) q1.push_back('{edge_cnt + 2 + NP*DW1, led});
    @(negedge clk);
    s1 = 1'b0;
  endtask

  task automatic wait_d1(input int budget);
    int n = 0;
    while (!d1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("d1_done_timeout", {31'd0, d1}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    if (DW3 < 1 || DW3 > 255) begin
      $display("FAIL dwell_param: DWELL=%0d outside 1..255", DW3);
      $fatal(1);
    end

    rst = 1'b1;
    s1 = 0; c1 = 0; i1 = '0;
    s3 = 0; c3 = 0; i3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_o_led", {25'd0, l1}, 0);
    chk("rst_busy", {31'd0, b1}, 0);
    chk("rst_done", {31'd0, d1}, 0);
    chk("rst_o_led3", {25'd0, l3}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", {31'd0, b1}, 0);

    // All ones: busy for cycles 1..9, result from cycle 10.
    go1(14'h3FFF, 1'b1, 7'h7F);
    for (int c = 1; c <= 9; c++) begin
      chk("busy_in_scan", {31'd0, b1}, 1);
      @(negedge clk);
    end
    chk("busy_cycle10", {31'd0, b1}, 0);
    chk("o_led_cycle10", {25'd0, l1}, 32'h7F);

    // Mixed pattern; old o_led holds throughout the scan.
    go1(14'b01_00_10_00_11_00_01, 1'b1, 7'b1010101);
    for (int c = 1; c <= 8; c++) begin
      chk("o_led_hold", {25'd0, l1}, 32'h7F);
      @(negedge clk);
    end
    wait_d1(20);
    @(negedge clk);
    chk("o_led_pattern", {25'd0, l1}, 32'h55);

    // Input changes after capture and a start while busy are both ignored.
    go1(14'h0000, 1'b1, 7'h00);
    @(negedge clk);
    i1 = 14'h3FFF;
    repeat (3) @(negedge clk);
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    wait_d1(30);
    repeat (6) @(negedge clk);

    // Continuous mode, entered with start and cont_mode together.
    @(negedge clk);
    i1 = 14'h0000;
    c1 = 1'b1;
    s1 = 1'b1;
    for (int n = 0; n < 4; n++)
      q1.push_back('{edge_cnt + 2 + NP*DW1 + 9*n, (n % 2 == 1) ? 7'h7F : 7'h00});
    @(negedge clk);
    s1 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      wait_d1(30);
      i1 = (n % 2 == 0) ? 14'h3FFF : 14'h0000;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    c1 = 1'b0;
    wait_d1(30);
    repeat (4) @(negedge clk);
    chk("idle_after_cont", {31'd0, b1}, 0);

    // Reset mid-scan aborts without publishing.
    go1(14'h3FFF, 1'b0, 7'h00);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_o_led", {25'd0, l1}, 0);
    chk("abort_busy", {31'd0, b1}, 0);
    chk("abort_done", {31'd0, d1}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("no_scan_after_rst", {31'd0, b1}, 0);
    chk("o_led_after_abort", {25'd0, l1}, 0);

    // DWELL=3 scan with a start re-pulsed in cycle 5.
    @(negedge clk);
    i3 = 14'h0001;
    s3 = 1'b1;
    q3.push_back('{edge_cnt + 2 + NP*DW3, 7'h01});
    @(negedge clk);
    s3 = 1'b0;
    repeat (4) @(negedge clk);
    s3 = 1'b1;
    @(negedge clk);
    s3 = 1'b0;
    begin
      int n = 0;
      while (!d3 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("d3_done_timeout", {31'd0, d3}, 1);
    end
    @(negedge clk);
    chk("d3_o_led_after", {25'd0, l3}, 32'h01);
    repeat (30) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
